// File: rtl/cpu_input_scheduler.sv
// rtl/cpu_input_scheduler.sv - CPU opponent button scheduler driven by an external LFSR
module cpu_input_scheduler #(
    parameter int HOLD_BASE = 6,
    parameter int GAP_BASE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       active,
    input  logic       freeze,
    input  logic [1:0] difficulty,
    input  logic [3:0] lfsr_bits,
    output logic       lfsr_en,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_attack,
    output logic       decision_valid,
    output logic [7:0] decision_cnt
);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_BASE);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROLL,
        S_SAMPLE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       hold_left;
    logic       hold_right;
    logic       attack_live;

    logic       tick;
    logic [7:0] gap_len;
    logic [7:0] hold_len;
    logic       dec_left;
    logic       dec_right;
    logic       dec_attack;

    // A frozen frame does not advance anything, so a coincident tick is dropped here.
    assign tick       = frame_tick & ~freeze;
    assign gap_len    = GAP_LOAD >> difficulty;
    assign hold_len   = HOLD_LOAD + {7'd0, lfsr_bits[3]};
    // Left and right together would cancel out, so that combination means "stand still".
    assign dec_left   = lfsr_bits[1] & ~lfsr_bits[2];
    assign dec_right  = lfsr_bits[2] & ~lfsr_bits[1];
    assign dec_attack = lfsr_bits[0];

    // Decision sequencer: roll the LFSR, sample and decode it, hold the buttons, then back off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 8'd0;
            hold_left      <= 1'b0;
            hold_right     <= 1'b0;
            attack_live    <= 1'b0;
            lfsr_en        <= 1'b0;
            btn_left       <= 1'b0;
            btn_right      <= 1'b0;
            btn_attack     <= 1'b0;
            decision_valid <= 1'b0;
            decision_cnt   <= 8'd0;
        end else begin
            lfsr_en        <= 1'b0;
            decision_valid <= 1'b0;
            btn_left       <= 1'b0;
            btn_right      <= 1'b0;
            btn_attack     <= 1'b0;

            if (state == S_ROLL) begin
                // The step pulse is already on the output; only the follow-on is cancelled.
                if (active) begin
                    state <= S_SAMPLE;
                end else begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end
            end else if (!active) begin
                state       <= S_IDLE;
                cnt         <= 8'd0;
                hold_left   <= 1'b0;
                hold_right  <= 1'b0;
                attack_live <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tick) begin
                            state   <= S_ROLL;
                            lfsr_en <= 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        hold_left      <= dec_left;
                        hold_right     <= dec_right;
                        attack_live    <= dec_attack;
                        cnt            <= hold_len;
                        decision_cnt   <= decision_cnt + 8'd1;
                        decision_valid <= 1'b1;
                        btn_left       <= dec_left & ~freeze;
                        btn_right      <= dec_right & ~freeze;
                        btn_attack     <= dec_attack & ~freeze;
                        state          <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (tick) begin
                            // The attack is a single-frame press: the first counted frame consumes it.
                            attack_live <= 1'b0;
                            if (cnt == 8'd1) begin
                                if (gap_len == 8'd0) begin
                                    state   <= S_ROLL;
                                    lfsr_en <= 1'b1;
                                    cnt     <= 8'd0;
                                end else begin
                                    state <= S_GAP;
                                    cnt   <= gap_len;
                                end
                            end else begin
                                cnt       <= cnt - 8'd1;
                                btn_left  <= hold_left;
                                btn_right <= hold_right;
                            end
                        end else begin
                            btn_left   <= hold_left & ~freeze;
                            btn_right  <= hold_right & ~freeze;
                            btn_attack <= attack_live & ~freeze;
                        end
                    end
                    S_GAP: begin
                        if (tick) begin
                            if (cnt == 8'd1) begin
                                state   <= S_ROLL;
                                lfsr_en <= 1'b1;
                                cnt     <= 8'd0;
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_input_scheduler.sv
// tb/tb_cpu_input_scheduler.sv - self-checking bench for cpu_input_scheduler
module tb_cpu_input_scheduler;
    typedef enum int {P_IDLE, P_ROLL, P_SAMPLE, P_HOLD, P_GAP} phase_t;

    typedef struct {
        phase_t ph;
        int     need;
        int     seen;
        bit     l;
        bit     r;
        bit     a;
        bit     first;
        int     dc;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       active = 1'b0;
    logic       freeze = 1'b0;
    logic [1:0] difficulty = 2'd0;
    logic       force_conflict = 1'b0;

    logic [3:0] lfsr_q [2];
    logic [3:0] bits   [2];
    logic       en_o   [2];
    logic       l_o    [2];
    logic       r_o    [2];
    logic       a_o    [2];
    logic       dv_o   [2];
    logic [7:0] dc_o   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int div    = 0;

    always #5 clk = ~clk;

    assign bits[0] = force_conflict ? 4'b0111 : lfsr_q[0];
    assign bits[1] = force_conflict ? 4'b0111 : lfsr_q[1];

    cpu_input_scheduler #(.HOLD_BASE(6), .GAP_BASE(8)) u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .active(active), .freeze(freeze),
        .difficulty(difficulty), .lfsr_bits(bits[0]), .lfsr_en(en_o[0]),
        .btn_left(l_o[0]), .btn_right(r_o[0]), .btn_attack(a_o[0]),
        .decision_valid(dv_o[0]), .decision_cnt(dc_o[0])
    );

    cpu_input_scheduler #(.HOLD_BASE(6), .GAP_BASE(0)) u_dut_nogap (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .active(active), .freeze(freeze),
        .difficulty(difficulty), .lfsr_bits(bits[1]), .lfsr_en(en_o[1]),
        .btn_left(l_o[1]), .btn_right(r_o[1]), .btn_attack(a_o[1]),
        .decision_valid(dv_o[1]), .decision_cnt(dc_o[1])
    );

    // Stand-in random generator: walks 0001 -> 0010 -> 0100 -> 1000 -> 0001 on each step.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) lfsr_q[k] <= 4'b0001;
            else if (en_o[k]) lfsr_q[k] <= {lfsr_q[k][2:0], lfsr_q[k][3]};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: phase plus frames seen versus frames needed for the current phase.
    function automatic mstate_t model_next(mstate_t s, bit act, bit tk, int gap_frames, logic [3:0] b);
        mstate_t n = s;
        n.first = 1'b0;
        if (s.ph == P_ROLL) begin
            n.ph = act ? P_SAMPLE : P_IDLE;
        end else if (!act) begin
            n.ph = P_IDLE; n.need = 0; n.seen = 0; n.l = 0; n.r = 0; n.a = 0;
        end else begin
            case (s.ph)
                P_IDLE: if (tk) n.ph = P_ROLL;
                P_SAMPLE: begin
                    n.a = b[0];
                    n.l = b[1] && !b[2];
                    n.r = b[2] && !b[1];
                    n.need = 6 + int'(b[3]);
                    n.seen = 0;
                    n.dc = (s.dc + 1) % 256;
                    n.first = 1'b1;
                    n.ph = P_HOLD;
                end
                P_HOLD: if (tk) begin
                    n.a = 1'b0;
                    n.seen = s.seen + 1;
                    if (n.seen == s.need) begin
                        n.seen = 0;
                        n.need = gap_frames;
                        n.ph = (gap_frames == 0) ? P_ROLL : P_GAP;
                    end
                end
                P_GAP: if (tk) begin
                    n.seen = s.seen + 1;
                    if (n.seen == s.need) begin
                        n.seen = 0;
                        n.ph = P_ROLL;
                    end
                end
                default: n.ph = P_IDLE;
            endcase
        end
        return n;
    endfunction

    mstate_t ms [2];
    bit      m_fq;

    // Advance the model once per clock from the inputs the DUT sees on that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                ms[k] <= '{ph: P_IDLE, need: 0, seen: 0, l: 0, r: 0, a: 0, first: 0, dc: 0};
            end
            m_fq <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                ms[k] <= model_next(ms[k], active, frame_tick && !freeze,
                                    ((k == 0) ? 8 : 0) / (1 << difficulty), bits[k]);
            end
            m_fq <= freeze;
        end
    end

    // Every cycle out of reset, both instances must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d lfsr_en", k), en_o[k], ms[k].ph == P_ROLL);
                chk($sformatf("u%0d btn_left", k), l_o[k], ms[k].ph == P_HOLD && !m_fq && ms[k].l);
                chk($sformatf("u%0d btn_right", k), r_o[k], ms[k].ph == P_HOLD && !m_fq && ms[k].r);
                chk($sformatf("u%0d btn_attack", k), a_o[k], ms[k].ph == P_HOLD && !m_fq && ms[k].a);
                chk($sformatf("u%0d decision_valid", k), dv_o[k], ms[k].first);
                chk($sformatf("u%0d decision_cnt", k), dc_o[k], ms[k].dc);
            end
        end
    end

    // Frame bookkeeping between decisions, observed only from DUT pulses.
    int t0, tall0, per0, perall0, t1, en1;
    int q_per1 [$];
    int q_en1  [$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t0 <= 0; tall0 <= 0; per0 <= 0; perall0 <= 0; t1 <= 0; en1 <= 0;
            q_per1.delete();
            q_en1.delete();
        end else begin
            if (dv_o[0]) begin
                t0    <= (frame_tick && !freeze) ? 1 : 0;
                tall0 <= frame_tick ? 1 : 0;
            end else begin
                t0    <= t0 + ((frame_tick && !freeze) ? 1 : 0);
                tall0 <= tall0 + (frame_tick ? 1 : 0);
            end
            if (en_o[0]) begin
                per0    <= t0;
                perall0 <= tall0;
            end
            if (dv_o[1]) begin
                t1  <= (frame_tick && !freeze) ? 1 : 0;
                q_en1.push_back(en1);
                en1 <= 0;
            end else begin
                t1  <= t1 + ((frame_tick && !freeze) ? 1 : 0);
                en1 <= en1 + (en_o[1] ? 1 : 0);
            end
            if (en_o[1]) q_per1.push_back(t1);
        end
    end

    // One clock of stimulus; frame_tick fires every sixth cycle.
    task automatic step();
        @(negedge clk);
        div = (div == 5) ? 0 : div + 1;
        frame_tick = (div == 5);
    endtask

    task automatic wait_dv(input int k, input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!dv_o[k] && n < 600);
        chk({nm, " decision_valid seen"}, dv_o[k], 1);
    endtask

    task automatic chk_btn(input string nm, input bit l, input bit r, input bit a);
        chk({nm, " left"}, l_o[0], l);
        chk({nm, " right"}, r_o[0], r);
        chk({nm, " attack"}, a_o[0], a);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fz, ens;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset lfsr_en", en_o[0], 0);
        chk_btn("reset", 0, 0, 0);
        chk("reset decision_valid", dv_o[0], 0);
        chk("reset decision_cnt", dc_o[0], 0);

        active = 1'b1;
        wait_dv(0, "dec1");
        chk_btn("dec1 0010", 1, 0, 0);
        wait_dv(0, "dec2");
        chk_btn("dec2 0100", 0, 1, 0);
        chk("dec1 period frames", per0, 14);
        wait_dv(0, "dec3");
        chk_btn("dec3 1000", 0, 0, 0);
        chk("dec2 period frames", per0, 14);
        wait_dv(0, "dec4");
        chk_btn("dec4 0001", 0, 0, 1);
        chk("dec3 period frames", per0, 15);
        chk("decision_cnt after four", dc_o[0], 4);

        chk("nogap periods recorded", q_per1.size() >= 4, 1);
        if (q_per1.size() >= 4) begin
            chk("nogap dec1 period", q_per1[1], 6);
            chk("nogap dec2 period", q_per1[2], 6);
            chk("nogap dec3 period", q_per1[3], 7);
        end
        chk("nogap decisions recorded", q_en1.size() >= 3, 1);
        foreach (q_en1[i]) chk($sformatf("nogap lfsr_en per decision %0d", i), q_en1[i], 1);

        difficulty = 2'd3;
        wait_dv(0, "dec5");
        chk("dec4 period at difficulty 3", per0, 7);
        wait_dv(0, "dec6");
        chk("dec5 period at difficulty 3", per0, 7);

        force_conflict = 1'b1;
        wait_dv(0, "conflict");
        force_conflict = 1'b0;
        chk_btn("conflict 0111", 0, 0, 1);

        wait_dv(0, "dec8");
        wait_dv(0, "dec9");
        chk_btn("dec9 0010", 1, 0, 0);
        n = 0;
        while (!frame_tick && n < 20) begin
            step();
            n++;
        end
        step();
        freeze = 1'b1;
        fz = 0;
        n = 0;
        while (fz < 5 && n < 100) begin
            step();
            n++;
            if (frame_tick) fz++;
        end
        chk("frozen left", l_o[0], 0);
        step();
        freeze = 1'b0;
        step();
        chk("left restored after freeze", l_o[0], 1);
        chk("attack stays consumed", a_o[0], 0);

        wait_dv(0, "dec10");
        chk("frozen decision total frames", perall0, 12);
        chk("frozen decision counted frames", per0, 7);
        chk("dec10 right", r_o[0], 1);
        step();
        step();
        active = 1'b0;
        step();
        chk_btn("deactivated", 0, 0, 0);
        ens = 0;
        repeat (40) begin
            step();
            ens += en_o[0] ? 1 : 0;
        end
        chk("lfsr_en while inactive", ens, 0);
        difficulty = 2'd0;
        active = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!en_o[0] && n < 20);
        chk("lfsr_en after reactivate", en_o[0], 1);

        wait_dv(0, "dec11");
        chk_btn("dec11 1000", 0, 0, 0);
        n = 0;
        while (t0 < 9 && n < 200) begin
            step();
            n++;
        end
        chk("reached gap frames", t0, 9);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst lfsr_en", en_o[0], 0);
        chk_btn("async rst", 0, 0, 0);
        chk("async rst decision_valid", dv_o[0], 0);
        chk("async rst decision_cnt", dc_o[0], 0);
        step();
        step();
        rst = 1'b0;
        wait_dv(0, "post reset");
        chk_btn("post reset 0010", 1, 0, 0);
        chk("post reset decision_cnt", dc_o[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
